// File: rtl/uart_rx_if.sv
// Serial-line and received-word signals of the UART receiver.
// The master side drives the line and oversample tick; the slave side is the receiver.
interface uart_rx_if #(
  parameter int unsigned NBITS = 8
);
  logic             rx;
  logic             rx_clk;
  logic [NBITS-1:0] orx_data;
  logic             rx_done;
  logic             rx_frame_err;

  modport master (
    output rx,
    output rx_clk,
    input  orx_data,
    input  rx_done,
    input  rx_frame_err
  );

  modport slave (
    input  rx,
    input  rx_clk,
    output orx_data,
    output rx_done,
    output rx_frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, 2-flop synchronised input, LSB first, one stop bit.
// Define UART_RX_FRAME_ERR_EN to reject frames whose stop bit is sampled low.
module uart_rx #(
  parameter int unsigned NBITS = 8
) (
  input logic      clk,
  input logic      rstn,
  uart_rx_if.slave bus_io
);

  localparam int unsigned BitW = (NBITS > 1) ? $clog2(NBITS) : 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e           state_q, state_d;
  logic [3:0]       tick_q, tick_d;
  logic [BitW-1:0]  bit_q, bit_d;
  logic [NBITS-1:0] shift_q, shift_d;
  logic [NBITS-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic             rx_meta_q, rx_s_q;

`ifdef UART_RX_FRAME_ERR_EN
  logic ferr_q, ferr_d;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= StIdle;
      tick_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
      ferr_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q <= bus_io.rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      done_q    <= done_d;
`ifdef UART_RX_FRAME_ERR_EN
      ferr_q    <= ferr_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
`ifdef UART_RX_FRAME_ERR_EN
    ferr_d  = 1'b0;
`endif

    unique case (state_q)
      // Start detect does not wait for a tick so the bit phase is set by the edge itself.
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          tick_d  = '0;
        end
      end

      StStart: begin
        if (bus_io.rx_clk) begin
          if (tick_q == 4'd7) begin
            tick_d  = '0;
            state_d = rx_s_q ? StIdle : StData;
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end

      StData: begin
        if (bus_io.rx_clk) begin
          if (tick_q == 4'd15) begin
            tick_d  = '0;
            shift_d = {rx_s_q, shift_q[NBITS-1:1]};
            if (bit_q == BitW'(NBITS - 1)) begin
              bit_d   = '0;
              state_d = StStop;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end

      StStop: begin
        if (bus_io.rx_clk) begin
          if (tick_q == 4'd15) begin
            tick_d  = '0;
            state_d = StIdle;
`ifdef UART_RX_FRAME_ERR_EN
            if (rx_s_q) begin
              done_d = 1'b1;
              data_d = shift_q;
            end else begin
              ferr_d = 1'b1;
            end
`else
            done_d = 1'b1;
            data_d = shift_q;
`endif
          end else begin
            tick_d = tick_q + 4'd1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  assign bus_io.orx_data = data_q;
  assign bus_io.rx_done  = done_q;
`ifdef UART_RX_FRAME_ERR_EN
  assign bus_io.rx_frame_err = ferr_q;
`else
  assign bus_io.rx_frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Randomised and directed bench for uart_rx: a frame-level model predicts each
// completion pulse and the held word; a compare process checks every cycle.
module tb_uart_rx;
  localparam int unsigned NB = 8;

  typedef struct {
    bit             ferr;
    logic [NB-1:0]  data;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  logic stall;
  logic [1:0] div = 2'd0;

  uart_rx_if #(.NBITS(NB)) bus ();

  uart_rx #(.NBITS(NB)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int ferr_cnt = 0;
  exp_t exp_q[$];
  logic [NB-1:0] exp_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  // Oversample tick: one clk wide, every 4 clk, suppressible for stall tests.
  initial begin
    bus.rx_clk = 1'b0;
    forever begin
      @(negedge clk);
      div = div + 2'd1;
      bus.rx_clk = (div == 2'd0) && !stall;
    end
  end

  // Compare process: DUT outputs against the frame-level model every cycle.
  initial begin
    bit rst_edge;
    exp_t e;
    forever begin
      @(posedge clk);
      rst_edge = !rstn;
      @(negedge clk);
      if (rst_edge) begin
        exp_q.delete();
        exp_data = '0;
        check("rst_orx_data", 32'(bus.orx_data), 32'(exp_data));
        check("rst_rx_done", 32'(bus.rx_done), 32'd0);
        check("rst_frame_err", 32'(bus.rx_frame_err), 32'd0);
      end else begin
        check("done_ferr_exclusive", 32'(bus.rx_done & bus.rx_frame_err), 32'd0);
        if (bus.rx_done || bus.rx_frame_err) begin
          check("pulse_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pulse_kind_ferr", 32'(bus.rx_frame_err), 32'(e.ferr));
            if (!e.ferr) exp_data = e.data;
          end
          if (bus.rx_done) done_cnt++;
          if (bus.rx_frame_err) ferr_cnt++;
        end
        check("orx_data", 32'(bus.orx_data), 32'(exp_data));
      end
    end
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; ) begin
      @(posedge clk);
      if (bus.rx_clk) i++;
    end
    @(negedge clk);
  endtask

  // Drives one frame; a low stop bit lasts 12 ticks so it cannot be mistaken for a start bit.
  task automatic send_frame(input logic [NB-1:0] d, input bit stop, input int stall_bit);
    exp_t e;
`ifdef UART_RX_FRAME_ERR_EN
    e.ferr = !stop;
`else
    e.ferr = 1'b0;
`endif
    e.data = d;
    exp_q.push_back(e);
    bus.rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < int'(NB); i++) begin
      bus.rx = d[i];
      if (i == stall_bit) begin
        wait_ticks(8);
        stall = 1'b1;
        repeat (100) @(negedge clk);
        stall = 1'b0;
        wait_ticks(8);
      end else begin
        wait_ticks(16);
      end
    end
    bus.rx = stop;
    wait_ticks(12);
    bus.rx = 1'b1;
    wait_ticks(4);
    check("frame_completed", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int d0;
    int f0;
    int exp_done;
    int exp_ferr;
    logic [NB-1:0] rd;
    bit rs;
    rstn   = 1'b0;
    stall  = 1'b0;
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("init_orx_data", 32'(bus.orx_data), 32'h0);
    check("init_rx_done", 32'(bus.rx_done), 32'h0);

    // Good frame
    d0 = done_cnt;
    send_frame(8'hA5, 1'b1, -1);
    check("a5_data", 32'(bus.orx_data), 32'hA5);
    check("a5_one_done", 32'(done_cnt - d0), 32'd1);

    // Glitch shorter than half a bit
    d0 = done_cnt;
    bus.rx = 1'b0;
    wait_ticks(3);
    bus.rx = 1'b1;
    wait_ticks(24);
    check("glitch_no_done", 32'(done_cnt - d0), 32'd0);
    check("glitch_data_kept", 32'(bus.orx_data), 32'hA5);

    // Framing error
    d0 = done_cnt;
    f0 = ferr_cnt;
    send_frame(8'h3C, 1'b0, -1);
`ifdef UART_RX_FRAME_ERR_EN
    check("ferr_pulse", 32'(ferr_cnt - f0), 32'd1);
    check("ferr_no_done", 32'(done_cnt - d0), 32'd0);
    check("ferr_data_kept", 32'(bus.orx_data), 32'hA5);
`else
    check("noferr_pulse", 32'(ferr_cnt - f0), 32'd0);
    check("noferr_done", 32'(done_cnt - d0), 32'd1);
    check("noferr_data", 32'(bus.orx_data), 32'h3C);
`endif
    wait_ticks(16);

    // Back-to-back frames
    d0 = done_cnt;
    send_frame(8'h00, 1'b1, -1);
    check("b2b_first", 32'(bus.orx_data), 32'h00);
    send_frame(8'hFF, 1'b1, -1);
    check("b2b_second", 32'(bus.orx_data), 32'hFF);
    check("b2b_two_done", 32'(done_cnt - d0), 32'd2);

    // Reset during data bit 4 of 0x55, then a fresh frame
    d0 = done_cnt;
    rd = 8'h55;
    bus.rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      bus.rx = rd[i];
      wait_ticks(16);
    end
    bus.rx = rd[4];
    wait_ticks(8);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    bus.rx = 1'b1;
    wait_ticks(32);
    check("rst_abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("rst_abort_data", 32'(bus.orx_data), 32'h00);
    send_frame(8'h81, 1'b1, -1);
    check("post_rst_data", 32'(bus.orx_data), 32'h81);
    check("post_rst_done", 32'(done_cnt - d0), 32'd1);

    // Stalled tick mid-data
    send_frame(8'h6B, 1'b1, 3);
    check("stall_data", 32'(bus.orx_data), 32'h6B);

    // Randomised frames, stop bits, gaps and stalls
    d0 = done_cnt;
    f0 = ferr_cnt;
    exp_done = 0;
    exp_ferr = 0;
    for (int n = 0; n < 24; n++) begin
      rd = NB'($urandom);
      rs = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_FRAME_ERR_EN
      if (rs) exp_done++;
      else exp_ferr++;
`else
      exp_done++;
`endif
      send_frame(rd, rs, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NB - 1)) : -1);
      wait_ticks(16 * int'($urandom_range(0, 2)));
    end
    check("rand_done_count", 32'(done_cnt - d0), 32'(exp_done));
    check("rand_ferr_count", 32'(ferr_cnt - f0), 32'(exp_ferr));

    wait_ticks(4);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL provide parameter NBITS, default 8, meaning the number of data bits per frame.
REQ-002 SHALL provide port clk, input, 1 bit: the single clock for all logic.
REQ-003 SHALL provide port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL provide port rx, input, 1 bit: asynchronous serial line, idle high.
REQ-005 SHALL provide port rx_clk, input, 1 bit: one-clk-wide oversample tick at 16x the baud rate.
REQ-006 SHALL provide port orx_data, output, NBITS bits: last correctly received word, LSB received first.
REQ-007 SHALL provide port rx_done, output, 1 bit: one-clk pulse when orx_data is updated.
REQ-008 SHALL provide port rx_frame_err, output, 1 bit: one-clk pulse when the stop bit is sampled low.

Function
REQ-009 SHALL pass rx through a 2-flop synchronizer; all FSM decisions use the synchronized value rx_s.
REQ-010 SHALL implement the states IDLE, START, DATA and STOP, plus a 4-bit tick counter and a bit counter wide enough for NBITS-1.
REQ-011 IDLE: SHALL move to START with the tick counter at 0 on the first clk where rx_s=0; rx_clk is not required for this transition.
REQ-012 START: SHALL increment the tick counter on each rx_clk. At tick count 7 (mid start bit), SHALL go to DATA with the counter cleared if rx_s=0, else return to IDLE (glitch reject).
REQ-013 DATA: SHALL increment the tick counter on each rx_clk. At count 15 it SHALL shift rx_s into the MSB of the shift register (shift right), clear the counter, and increment the bit counter.
REQ-014 DATA: after the bit with index NBITS-1 is sampled, SHALL go to STOP and clear the bit counter.
REQ-015 STOP: SHALL sample rx_s at tick count 15, clear the counter, and return to IDLE on that same transition.
REQ-016 rx_done SHALL assert on the clk after the stop-sample tick; orx_data SHALL update on that same edge and hold until the next good frame.
REQ-017 When rx_clk is low, the FSM and counters SHALL hold, except for the IDLE start detect.
REQ-018 rx_done and rx_frame_err SHALL never be high in the same cycle.
REQ-019 A new start bit seen in IDLE immediately after STOP SHALL be accepted, allowing back-to-back frames with no idle gap beyond the stop bit.

Reset
REQ-020 On a clk edge with rstn=0, the block SHALL go to IDLE, clear the counters and shift register, set orx_data=0, rx_done=0 and rx_frame_err=0, and set both synchronizer flops to 1.
REQ-021 A reset asserted mid-frame SHALL abort the frame with no rx_done pulse; reception SHALL resume on the next falling edge after rstn=1.

Configuration
REQ-022 Macro UART_RX_FRAME_ERR_EN SHALL control stop-bit checking.
REQ-023 With the macro defined and the stop bit sampled low:
- rx_frame_err SHALL pulse for one clk.
- rx_done SHALL stay low.
- orx_data SHALL keep its previous value.
REQ-024 With the macro undefined:
- rx_frame_err SHALL be tied to 0.
- The stop-bit value SHALL be ignored, and rx_done/orx_data SHALL update for every frame.

Verification
REQ-025 Good frame: NBITS=8, rx_clk every 4 clk, send 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> one rx_done pulse, orx_data=0xA5, rx_frame_err=0.
REQ-026 Glitch: rx low for 3 rx_clk ticks, then high -> FSM back in IDLE, no rx_done, orx_data unchanged.
REQ-027 Framing error with the macro defined: send 0x3C with stop=0 -> rx_frame_err pulses once, no rx_done, orx_data keeps the prior value 0xA5; without the macro -> rx_done pulses and orx_data=0x3C.
REQ-028 Back-to-back: 0x00 then 0xFF with no idle gap -> two rx_done pulses, orx_data=0x00 then 0xFF.
REQ-029 Reset mid-frame: rstn=0 for 2 clk during data bit 4 of 0x55, then send 0x81 -> no pulse for the aborted frame, then rx_done with orx_data=0x81.
REQ-030 Stalled tick: hold rx_clk=0 for 100 clk in the middle of DATA -> counters hold, and the frame completes correctly once ticks resume.
